// File: rtl/cabac_ep_fifo.sv
// Emulation-prevention inserter plus show-ahead byte FIFO. Writes land on the next edge; the head byte is combinational.
// No backpressure: bytes beyond free space are dropped and flagged sticky in overflow. The consumer throttles upstream with almost_full.
module cabac_ep_fifo #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    input  logic          slice_done,
    input  logic          out_rd,
    output logic          out_valid,
    output logic [7:0]    out_byte,
    output logic [AW:0]   fifo_cnt,
    output logic          almost_full,
    output logic          overflow,
    output logic [15:0]   ep_cnt
);

    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [AW:0]   AF_LVL  = (AW+1)'(DEPTH - 4);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [1:0]    zc_q, zc_d;
    logic [15:0]   ep_q, ep_d;
    logic          ovf_q, ovf_d;

    logic [7:0]    wb0, wb1, wb2;
    logic [1:0]    n_wr;
    logic [1:0]    n_ins;
    logic [1:0]    zc_mid;
    logic          pop;
    logic [AW+1:0] free;
    logic          drop;
    logic [1:0]    n_acc;
    logic [16:0]   ep_sum;

    // Logical output stream for this cycle: up to three bytes, in order.
    always_comb begin
        wb0    = 8'h00;
        wb1    = 8'h00;
        wb2    = 8'h00;
        n_wr   = 2'd0;
        n_ins  = 2'd0;
        zc_mid = zc_q;
        if (in_valid) begin
            if (zc_q == 2'd2 && in_byte <= 8'h03) begin
                wb0    = 8'h03;
                wb1    = in_byte;
                n_wr   = 2'd2;
                n_ins  = 2'd1;
                zc_mid = (in_byte == 8'h00) ? 2'd1 : 2'd0;
            end else begin
                wb0    = in_byte;
                n_wr   = 2'd1;
                if (in_byte == 8'h00) begin
                    zc_mid = (zc_q == 2'd2) ? 2'd2 : zc_q + 2'd1;
                end else begin
                    zc_mid = 2'd0;
                end
            end
        end
        zc_d = zc_mid;
        if (slice_done) begin
            if (zc_mid != 2'd0) begin
                case (n_wr)
                    2'd0:    wb0 = 8'h03;
                    2'd1:    wb1 = 8'h03;
                    default: wb2 = 8'h03;
                endcase
                n_wr  = n_wr + 2'd1;
                n_ins = n_ins + 2'd1;
            end
            zc_d = 2'd0;
        end
    end

    // A pop this cycle frees its slot for a same-cycle write; excess bytes fall off the tail.
    always_comb begin
        pop      = out_rd && (cnt_q != '0);
        free     = DEPTH_W - {1'b0, cnt_q} + {{(AW+1){1'b0}}, pop};
        drop     = ({{AW{1'b0}}, n_wr} > free);
        n_acc    = drop ? free[1:0] : n_wr;
        cnt_d    = cnt_q + {{(AW-1){1'b0}}, n_acc} - {{AW{1'b0}}, pop};
        wr_ptr_d = wr_ptr_q + {{(AW-2){1'b0}}, n_acc};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop};
        ovf_d    = ovf_q | drop;
        ep_sum   = {1'b0, ep_q} + {15'd0, n_ins};
        ep_d     = ep_sum[16] ? 16'hFFFF : ep_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            zc_q     <= 2'd0;
            ep_q     <= 16'd0;
            ovf_q    <= 1'b0;
        end else if (!en) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            zc_q     <= 2'd0;
            ep_q     <= 16'd0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            zc_q     <= zc_d;
            ep_q     <= ep_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately not reset; out_byte is meaningless while out_valid is low.
    always_ff @(posedge clk) begin
        if (en) begin
            if (n_acc >= 2'd1) mem_q[wr_ptr_q]           <= wb0;
            if (n_acc >= 2'd2) mem_q[wr_ptr_q + AW'(1)]  <= wb1;
            if (n_acc == 2'd3) mem_q[wr_ptr_q + AW'(2)]  <= wb2;
        end
    end

    assign out_byte    = mem_q[rd_ptr_q];
    assign out_valid   = (cnt_q != '0);
    assign fifo_cnt    = cnt_q;
    assign almost_full = (cnt_q >= AF_LVL);
    assign overflow    = ovf_q;
    assign ep_cnt      = ep_q;

endmodule

// File: tb/tb_cabac_ep_fifo.sv
// Randomized and directed bench for cabac_ep_fifo with a stream-level reference model and pop scoreboard.
module tb_cabac_ep_fifo;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          slice_done;
    logic          out_rd;
    logic          out_valid;
    logic [7:0]    out_byte;
    logic [AW:0]   fifo_cnt;
    logic          almost_full;
    logic          overflow;
    logic [15:0]   ep_cnt;

    cabac_ep_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_byte(in_byte),
        .slice_done(slice_done), .out_rd(out_rd), .out_valid(out_valid), .out_byte(out_byte),
        .fifo_cnt(fifo_cnt), .almost_full(almost_full), .overflow(overflow), .ep_cnt(ep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: expected FIFO contents, recent logical stream, counters.
    logic [7:0] exp_q[$];
    logic [7:0] hist[$];
    int         m_cnt = 0;
    int         m_ep  = 0;
    bit         m_ovf = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        hist.delete();
        m_cnt = 0;
        m_ep  = 0;
        m_ovf = 1'b0;
    endtask

    task automatic cycle(input bit v, input logic [7:0] b, input bit sd, input bit rd, input bit e);
        logic [7:0] emit[$];
        int  ins;
        bit  pop;
        int  free;
        int  acc;
        in_valid   = v;
        in_byte    = b;
        slice_done = sd;
        out_rd     = rd;
        en         = e;
        @(posedge clk);
        if (!e) begin
            model_clear();
        end else begin
            ins = 0;
            if (v) begin
                if (hist.size() >= 2 && hist[hist.size()-1] == 8'h00 &&
                    hist[hist.size()-2] == 8'h00 && b <= 8'h03) begin
                    emit.push_back(8'h03);
                    hist.push_back(8'h03);
                    ins++;
                end
                emit.push_back(b);
                hist.push_back(b);
            end
            if (sd) begin
                if (hist.size() > 0 && hist[hist.size()-1] == 8'h00) begin
                    emit.push_back(8'h03);
                    ins++;
                end
                hist.delete();
            end
            while (hist.size() > 2) void'(hist.pop_front());
            pop  = rd && (m_cnt > 0);
            free = DEPTH - m_cnt + int'(pop);
            acc  = (emit.size() < free) ? emit.size() : free;
            for (int i = 0; i < acc; i++) exp_q.push_back(emit[i]);
            if (emit.size() > acc) m_ovf = 1'b1;
            m_ep  = (m_ep + ins > 65535) ? 65535 : m_ep + ins;
            m_cnt = m_cnt + acc - int'(pop);
        end
        #2;
        chk("fifo_cnt", int'(fifo_cnt), m_cnt);
        chk("out_valid", int'(out_valid), int'(m_cnt != 0));
        chk("almost_full", int'(almost_full), int'(m_cnt >= DEPTH - 4));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("ep_cnt", int'(ep_cnt), m_ep);
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 8 && m_cnt > 0; k++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("drain_done", int'(fifo_cnt), 0);
    endtask

    task automatic clear();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: every DUT pop must match the oldest expected byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && en && out_rd && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_byte", int'(out_byte), int'(e));
                end
            end
        end
    end

    initial begin
        int rdp;
        bit v, sd, rd, e;
        logic [7:0] b;
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_byte = 8'h00; slice_done = 1'b0; out_rd = 1'b0;
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fifo_cnt", int'(fifo_cnt), 0);
        chk("rst_almost_full", int'(almost_full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_ep_cnt", int'(ep_cnt), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 00,00,01 -> 00,00,03,01
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        chk("zz01_cnt", int'(fifo_cnt), 4);
        chk("zz01_ep", int'(ep_cnt), 1);
        chk("zz01_head", int'(out_byte), 0);
        drain();
        clear();

        // 00 x4 -> 00,00,03,00,00 then trailer
        repeat (4) cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("zzzz_cnt", int'(fifo_cnt), 5);
        chk("zzzz_ep", int'(ep_cnt), 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("trailer_cnt", int'(fifo_cnt), 6);
        chk("trailer_ep", int'(ep_cnt), 2);
        drain();
        clear();

        // 00,00,04 -> no insertion
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h04, 1'b0, 1'b0, 1'b1);
        chk("zz04_cnt", int'(fifo_cnt), 3);
        chk("zz04_ep", int'(ep_cnt), 0);
        drain();
        clear();

        // DEPTH-1 stored ending in 00,00, then 02: 03 accepted, 02 dropped
        for (int i = 0; i < DEPTH - 3; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("full_pre_cnt", int'(fifo_cnt), DEPTH - 1);
        cycle(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
        chk("full_cnt", int'(fifo_cnt), DEPTH);
        chk("full_ovf", int'(overflow), 1);
        chk("full_af", int'(almost_full), 1);
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        chk("ovf_sticky", int'(overflow), 1);
        drain();
        chk("ovf_after_drain", int'(overflow), 1);
        clear();
        chk("ovf_cleared", int'(overflow), 0);

        // one byte held, pop + emulation write in same cycle, across pointer wrap
        for (int i = 0; i < DEPTH - 2; i++) cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("wrap_pre_cnt", int'(fifo_cnt), 1);
        cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
        chk("wrap_cnt", int'(fifo_cnt), 2);
        chk("wrap_head", int'(out_byte), 3);
        drain();
        clear();

        // asynchronous reset with 10 bytes stored
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b1);
        chk("arst_pre_cnt", int'(fifo_cnt), 10);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_fifo_cnt", int'(fifo_cnt), 0);
        model_clear();
        @(negedge clk);
        #1 rst_n = 1'b1;

        // synchronous clear via en=0 ignores same-cycle traffic
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("en0_out_valid", int'(out_valid), 0);
        chk("en0_fifo_cnt", int'(fifo_cnt), 0);
        chk("en0_ep_cnt", int'(ep_cnt), 0);
        chk("en0_overflow", int'(overflow), 0);

        // randomized traffic with varying read pressure
        for (int blk = 0; blk < 8; blk++) begin
            rdp = $urandom_range(1, 4);
            for (int c = 0; c < 200; c++) begin
                v  = ($urandom % 4) != 0;
                b  = (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
                sd = ($urandom % 12) == 0;
                rd = int'($urandom % 4) < rdp;
                e  = ($urandom % 150) != 0;
                cycle(v, b, sd, rd, e);
            end
        end
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
